// File: rtl/alu_traffic_gen.sv
// alu_traffic_gen: LFSR-driven ALU command generator with MISR result compression
module alu_traffic_gen #(
  parameter int          BITS       = 8,
  parameter int          NB_ALU_OPS = 16,
  parameter int          LATENCY    = 2,
  parameter logic [31:0] SEED       = 32'h1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [15:0]     i_nb_ops,
  output logic [4:0]      o_sel_op,
  output logic [BITS-1:0] o_op_a,
  output logic [BITS-1:0] o_op_b,
  input  logic [BITS-1:0] i_res,
  output logic            o_busy,
  output logic            o_done,
  output logic [15:0]     o_count,
  output logic [BITS-1:0] o_signature
);
  localparam logic [31:0] SEED0 = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] POLY  = 32'h80200003;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t          r_state, w_next;
  logic [31:0]     r_lfsr, w_l, w_l_next;
  logic [15:0]     r_n, r_issue, r_count;
  logic [LATENCY:0] r_vld;
  logic [4:0]      r_sel, w_sel;
  logic [BITS-1:0] r_a, r_b, r_sig, w_rot;
  logic            r_busy, r_done, w_start, w_issue, w_cap;
  generate
    if (BITS == 1) begin : g_rot1
      assign w_rot = r_sig;
    end else begin : g_rot
      assign w_rot = {r_sig[BITS-2:0], r_sig[BITS-1]};
    end
  endgenerate
  // r_lfsr holds the state for the next command; a start restarts from the seed
  always_comb begin
    w_start  = i_start && (r_state == IDLE || r_state == DONE);
    w_cap    = r_vld[LATENCY];
    w_issue  = (w_start && i_nb_ops != 16'd0) || (r_state == RUN && r_issue != r_n);
    w_l      = w_start ? SEED0 : r_lfsr;
    w_l_next = (w_l >> 1) ^ (w_l[0] ? POLY : 32'h0);
    w_sel    = ({1'b0, w_l[4:0]} < 6'(NB_ALU_OPS)) ? w_l[4:0] : 5'd0;
    w_next   = w_start ? ((i_nb_ops == 16'd0) ? DONE : RUN) :
               (r_state == RUN && r_issue == r_n) ? DRAIN :
               (r_state == DRAIN && w_cap && r_count + 16'd1 == r_n) ? DONE : r_state;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sel   <= 5'd0;
      r_a     <= '0;
      r_b     <= '0;
      r_lfsr  <= SEED0;
      r_n     <= 16'd0;
      r_issue <= 16'd0;
      r_vld   <= '0;
      r_count <= 16'd0;
      r_sig   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_sel   <= w_issue ? w_sel : 5'd0;
      r_a     <= w_issue ? w_l[BITS-1:0] : '0;
      r_b     <= w_issue ? w_l[31:32-BITS] : '0;
      r_lfsr  <= w_issue ? w_l_next : w_l;
      r_n     <= w_start ? i_nb_ops : r_n;
      r_issue <= (w_start ? 16'd0 : r_issue) + 16'(w_issue);
      r_vld   <= {r_vld[LATENCY-1:0], w_issue};
      r_count <= w_start ? 16'd0 : r_count + 16'(w_cap);
      r_sig   <= w_start ? '0 : w_cap ? (w_rot ^ i_res) : r_sig;
      r_busy  <= w_next == RUN || w_next == DRAIN;
      r_done  <= w_next == DONE;
    end
  end
  assign o_sel_op    = r_sel;
  assign o_op_a      = r_a;
  assign o_op_b      = r_b;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_count     = r_count;
  assign o_signature = r_sig;
endmodule
